// File: rtl/lipsi_prog_loader.sv
// -----------------------------------------------------------------------------
// lipsi_prog_loader
//
// Receives a framed program image over a byte stream and writes it into the
// Lipsi instruction memory while holding the processor in reset.
//
// Frame: HEADER, ADDR, LEN, LEN data bytes, CSUM   (LEN = 0 means 256 bytes)
// The 8-bit sum of ADDR, LEN, all data bytes and CSUM must be 0x00.
//
// Ports
//   clk        : clock, rising-edge active
//   reset      : asynchronous, active-high reset
//   in_valid   : in_data carries a byte this cycle
//   in_data    : incoming byte stream
//   in_ready   : loader accepts a byte (always 1 outside reset)
//   mem_we     : instruction-memory write strobe, one cycle per data byte
//   mem_addr   : instruction-memory write address
//   mem_wdata  : instruction-memory write data
//   cpu_hold   : processor held in reset (load in progress or last load failed)
//   load_done  : one-cycle pulse, frame complete with a good checksum
//   load_err   : one-cycle pulse, frame failed on checksum or timeout
//   busy       : FSM is outside IDLE
// -----------------------------------------------------------------------------
module lipsi_prog_loader #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int          TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err,
    output logic       busy
);

    localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // Modulo-256 accumulate used for the running checksum.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] val);
        return acc + val;
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    logic [7:0]        ptr_r;
    logic [7:0]        sum_r;
    logic [8:0]        cnt_r;
    logic [IDLE_W-1:0] idle_r;
    logic              in_ready_r;
    logic              mem_we_r;
    logic [7:0]        mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic              cpu_hold_r;
    logic              load_done_r;
    logic              load_err_r;

    logic              xfer_s;
    logic              timeout_s;
    logic              start_s;
    logic              addr_s;
    logic              len_s;
    logic              data_s;
    logic              csum_s;
    logic              csum_ok_s;

    assign xfer_s    = in_valid & in_ready_r;
    // Timeout fires on the TIMEOUT-th consecutive cycle without a handshake.
    assign timeout_s = (state_r != ST_IDLE) && !xfer_s && (idle_r == IDLE_LAST);
    assign csum_ok_s = (sum8(sum_r, in_data) == 8'h00);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and per-byte action strobes.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        addr_s     = 1'b0;
        len_s      = 1'b0;
        data_s     = 1'b0;
        csum_s     = 1'b0;
        if (timeout_s) begin
            state_nx_s = ST_IDLE;
        end else if (xfer_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_data == HEADER) begin
                        state_nx_s = ST_ADDR;
                        start_s    = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    addr_s     = 1'b1;
                    state_nx_s = ST_LEN;
                end
                ST_LEN: begin
                    len_s      = 1'b1;
                    state_nx_s = ST_DATA;
                end
                ST_DATA: begin
                    data_s = 1'b1;
                    if (cnt_r == 9'd1) begin
                        state_nx_s = ST_CSUM;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    csum_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Frame datapath: write pointer, running checksum and remaining count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 8'h00;
            sum_r <= 8'h00;
            cnt_r <= 9'd0;
        end else begin
            if (addr_s) begin
                ptr_r <= in_data;
                sum_r <= in_data;
            end else if (len_s) begin
                sum_r <= sum8(sum_r, in_data);
                // LEN of 0 encodes a full 256-byte page.
                cnt_r <= {(in_data == 8'h00), in_data};
            end else if (data_s) begin
                ptr_r <= ptr_r + 8'd1;
                sum_r <= sum8(sum_r, in_data);
                cnt_r <= cnt_r - 9'd1;
            end else begin
                ptr_r <= ptr_r;
                sum_r <= sum_r;
                cnt_r <= cnt_r;
            end
        end
    end

    // Idle counter: cleared on every handshake and while idle or timing out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_r <= '0;
        end else if (xfer_s || (state_r == ST_IDLE) || timeout_s) begin
            idle_r <= '0;
        end else begin
            idle_r <= idle_r + 1'b1;
        end
    end

    // Registered memory write port, one cycle behind the data-byte handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 8'h00;
            mem_wdata_r <= 8'h00;
        end else begin
            mem_we_r <= data_s;
            if (data_s) begin
                mem_addr_r  <= ptr_r;
                mem_wdata_r <= in_data;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Status outputs; cpu_hold stays set after a failure until a good frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r  <= 1'b0;
            cpu_hold_r  <= 1'b0;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            in_ready_r  <= 1'b1;
            load_done_r <= csum_s & csum_ok_s;
            // csum_s needs a handshake and timeout_s needs its absence,
            // so done and err can never coincide.
            load_err_r  <= (csum_s & ~csum_ok_s) | timeout_s;
            if (start_s) begin
                cpu_hold_r <= 1'b1;
            end else if (csum_s && csum_ok_s) begin
                cpu_hold_r <= 1'b0;
            end else begin
                cpu_hold_r <= cpu_hold_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign load_done = load_done_r;
    assign load_err  = load_err_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: doc/lipsi_prog_loader.md
LIPSI_PROG_LOADER -- requirements
Module: lipsi_prog_loader

Interface
REQ-001 Parameter HEADER, default 8'hA5, frame start byte.
REQ-002 Parameter TIMEOUT, default 1000000, maximum idle clk cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  clock; all state changes occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid byte this cycle.
REQ-006 in_data  input  8  incoming byte stream.
REQ-007 in_ready  output  1  loader can accept a byte; a byte transfers when in_valid and in_ready are both 1 at a rising edge.
REQ-008 mem_we  output  1  instruction-memory write strobe, one cycle per data byte.
REQ-009 mem_addr  output  8  instruction-memory write address.
REQ-010 mem_wdata  output  8  instruction-memory write data.
REQ-011 cpu_hold  output  1  holds the processor in reset while a load is in progress or has failed.
REQ-012 load_done  output  1  one-cycle pulse when a frame completes with a good checksum.
REQ-013 load_err  output  1  one-cycle pulse when a frame fails on checksum or timeout.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Frame format: HEADER, ADDR, LEN, LEN data bytes, CSUM; LEN=0 encodes 256 data bytes.
REQ-016 FSM states: IDLE, ADDR, LEN, DATA, CSUM; transitions occur only on an accepted byte, except on timeout.
REQ-017 IDLE: an accepted byte equal to HEADER moves the FSM to ADDR and sets cpu_hold=1; any other byte is discarded with no output change.
REQ-018 ADDR: the accepted byte loads the write pointer and seeds the running sum; FSM moves to LEN.
REQ-019 LEN: the accepted byte loads the 9-bit remaining count (0 -> 256) and is added to the sum; FSM moves to DATA.
REQ-020 DATA: each accepted byte produces one write, is added to the sum, increments the pointer modulo 256 (0xFF wraps to 0x00) and decrements the count; when the count reaches 0 the FSM moves to CSUM.
REQ-021 Write timing: mem_we, mem_addr and mem_wdata are registered and assert exactly 1 cycle after the data-byte handshake; mem_we is 0 in all other cycles.
REQ-022 Back-to-back data bytes (in_valid held high) produce writes on consecutive cycles.
REQ-023 Checksum: the 8-bit sum of ADDR, LEN, all data bytes and CSUM, taken modulo 256, must equal 0x00.
REQ-024 CSUM good: load_done pulses 1 cycle after the CSUM handshake, cpu_hold drops to 0 in the same cycle, and the FSM returns to IDLE.
REQ-025 CSUM bad: load_err pulses 1 cycle after the CSUM handshake, cpu_hold stays 1, and the FSM returns to IDLE; data already written is not undone.
REQ-026 Timeout: an idle counter clears on every handshake and counts cycles without one outside IDLE; reaching TIMEOUT pulses load_err, returns the FSM to IDLE and leaves cpu_hold at 1.
REQ-027 cpu_hold is sticky after an error and clears only on the next successful frame.
REQ-028 in_ready is 1 whenever reset is deasserted; the loader never back-pressures.
REQ-029 A HEADER byte received inside a frame is treated as ordinary frame content, with no resynchronisation.
REQ-030 load_done and load_err are never asserted in the same cycle.

Reset
REQ-031 While reset=1 (asynchronous): FSM=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, busy=0, and the sum, count and idle counter are 0.
REQ-032 Reset asserted mid-frame abandons the frame, and no further writes occur.

Verification
REQ-033 Good load: send A5,10,03,C7,0A,81,9B -> writes 0x10=C7, 0x11=0A, 0x12=81; load_done pulses once; cpu_hold=0; busy=0.
REQ-034 Bad checksum: send A5,10,03,C7,0A,81,9C -> same 3 writes; load_err pulses once; cpu_hold stays 1.
REQ-035 Address wrap: send A5,FE,03,11,22,33,99 -> writes FE=11, FF=22, 00=33; load_done pulses once.
REQ-036 Junk ignored: send 00,FF,3C, then the good-load frame -> no write and busy=0 during the junk bytes; result as REQ-033.
REQ-037 Timeout with TIMEOUT=16: send A5,10,03,C7, then hold in_valid=0 -> load_err pulses after 16 idle cycles; FSM=IDLE; cpu_hold=1; exactly 1 write occurred.
REQ-038 Reset mid-DATA: assert reset after the second data byte -> all outputs take REQ-031 values immediately; a subsequent good frame loads correctly.
